add_mod_pipe: RTL
=================

Name: add_mod_pipe

Overview:
- Pipelined modular adder with valid/ready handshake: result = (A + B >= q) ? (A + B − q) : (A + B).
- The addition-direction counterpart to the existing combinational modular subtractor. Feeds the butterfly/NTT datapath, where it absorbs downstream stalls without dropping or duplicating beats.
- Carries a sideband tag (address/index) alongside each beat.

Parameters:
- DATA_WIDTH, 16, operand/modulus/result width.
- TAG_WIDTH, 8, sideband tag width carried with each beat.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a_in  in  DATA_WIDTH  operand A, required < mod_in.
- b_in  in  DATA_WIDTH  operand B, required < mod_in.
- mod_in  in  DATA_WIDTH  modulus q, sampled per beat, q ≥ 2.
- tag_in  in  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- result  out  DATA_WIDTH  (A+B) mod q.
- tag_out  out  TAG_WIDTH  tag of the current output beat.
- busy  out  1  any pipeline stage holds a beat.

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset state: all stage valids = 0, out_valid = 0, result = 0, tag_out = 0, busy = 0, in_ready = 1 after reset release.
  - Reset asserted mid-operation discards all in-flight beats immediately; no output beat appears after reset release.
- Transfer rules:
  - An input beat transfers when in_valid & in_ready at a rising edge.
  - An output beat transfers when out_valid & out_ready at a rising edge.
- Stage 1 (S1), registered: sum = a_in + b_in at DATA_WIDTH+1 bits, so the carry is kept. mod_in and tag_in are registered with it.
- Stage 2 (S2), registered (drives outputs):
  - diff = sum − q at DATA_WIDTH+2 bits, signed.
  - result = diff negative ? sum[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0].
  - sum == q gives 0.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 beat/cycle with out_ready held high.
- Advance conditions:
  - S2 loads from S1 when s2 empty or (out_valid & out_ready).
  - S1 loads from input when s1 empty or S1 advances into S2.
  - in_ready = ~s1_valid | s1_advance.
- Backpressure:
  - While out_ready = 0 and out_valid = 1, result and tag_out hold stable.
  - With both stages full, in_ready = 0.
  - No beat is lost, duplicated or reordered.
- Simultaneous events:
  - With both stages full, out_ready = 1 and in_valid = 1 in the same cycle, one beat leaves, both stages shift and a new beat enters S1.
- in_ready has no combinational dependency on in_valid. in_ready depends combinationally on out_ready, which is allowed.
- Out-of-range operands (a or b ≥ q) get no checking. The output follows the formula above, truncated to DATA_WIDTH.
- busy = s1_valid | s2_valid.
- Signals with valid = 0 are don't-care except result and tag_out, which keep their last value.

Test Plan (DATA_WIDTH=16 unless stated):
- q=12289, a=12000, b=1000, out_ready=1 -> result=711 exactly 2 cycles after input transfer; tag echoed.
- q=12289, (a,b) = (5,7) -> result 12; (a,b) = (6144,6145) -> result 0. Streamed back-to-back, one beat per cycle, in order.
- q=65521, a=65520, b=65520 (sum carries into bit 16) -> result 65519; a=0, b=0 -> result 0.
- Stream 10 beats with tags 0..9 while out_ready toggles randomly. Hold out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepted beats;
  - result and tag_out stay stable while stalled;
  - all 10 results arrive in tag order, none missing or duplicated.
- Per-beat modulus change: beat1 q=17, a=9, b=9 -> 1; beat2 q=97, a=50, b=60 -> 13, issued back-to-back -> both correct.
- With both stages full, assert rst_n=0 for 1 cycle -> out_valid, busy and result go to 0 immediately; in_ready=1 after release; no stale beat appears afterwards.

Source files
------------

// File: rtl/add_mod_pipe.sv
// Two-stage pipelined modular adder: result = (a + b) mod q, with a sideband tag carried per beat.
// Latency: 2 cycles from input transfer to out_valid, 1 beat/cycle when out_ready stays high.
// Backpressure: stalls propagate stage by stage; in_ready drops only when both stages hold beats.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake; a_in, b_in, mod_in, tag_in sampled on transfer
//   out_valid / out_ready output handshake; result, tag_out valid with out_valid
//   busy                 high while either pipeline stage holds a beat
module add_mod_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] mod_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  busy
);

  // Stage 1 state: raw sum keeps the carry so a + b >= 2^DATA_WIDTH is reduced correctly.
  logic                  s1_valid;
  logic [DATA_WIDTH:0]   s1_sum;
  logic [DATA_WIDTH-1:0] s1_mod;
  logic [TAG_WIDTH-1:0]  s1_tag;

  // Stage 2 state drives the outputs directly.
  logic                  s2_valid;

  // Handshake / advance controls
  logic s2_load;    // S2 may take whatever S1 holds this cycle
  logic s1_advance; // a real beat moves S1 -> S2
  logic s1_load;    // a real beat moves input -> S1

  // Reduction datapath
  logic [DATA_WIDTH+1:0] diff;
  logic                  diff_neg;
  logic [DATA_WIDTH-1:0] result_nxt;
  logic                  diff_unused;

  // S2 frees up when it is empty or its beat is leaving this cycle.
  assign s2_load    = ~s2_valid | out_ready;
  assign s1_advance = s1_valid & s2_load;
  // Depends on out_ready through s2_load, never on in_valid.
  assign in_ready   = ~s1_valid | s1_advance;
  assign s1_load    = in_valid & in_ready;

  assign out_valid  = s2_valid;
  assign busy       = s1_valid | s2_valid;

  // Two extra bits: one for the kept carry, one as the sign of sum - q.
  assign diff        = {1'b0, s1_sum} - {2'b00, s1_mod};
  assign diff_neg    = diff[DATA_WIDTH+1];
  assign diff_unused = diff[DATA_WIDTH];

  always_comb begin
    result_nxt = diff[DATA_WIDTH-1:0];
    if (diff_neg) begin
      result_nxt = s1_sum[DATA_WIDTH-1:0];
    end
  end

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_mod   <= '0;
      s1_tag   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_load) begin
        s1_sum <= {1'b0, a_in} + {1'b0, b_in};
        s1_mod <= mod_in;
        s1_tag <= tag_in;
      end
    end
  end

  // Stage 2: data only updates on a real beat so result/tag_out keep their
  // last value while the pipeline drains or sits idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      tag_out  <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
      end
      if (s1_advance) begin
        result  <= result_nxt;
        tag_out <= s1_tag;
      end
    end
  end

endmodule
